bcd_subtractor_serial: RTL

- Multi-digit packed-BCD subtractor, the complementary operation to the team's single-digit combinational BCD adder.
- Computes A - B - bin serially, one decimal digit per clock, least significant digit first, with a ripple borrow.
- Start/busy/done handshake; sits in the decimal arithmetic datapath beside the adder.
- Negative results are returned in ten's complement with borrow-out set.

---
 rtl/bcd_subtractor_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_subtractor_serial.sv
// Serial packed-BCD subtractor: diff = A - B - bin, one decimal digit per clock, LSD first.
// Negative results are returned in ten's complement with bout set; non-BCD operands flag invalid.
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  invalid
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  borrow_q, borrow_d;
  logic [4*DIGITS-1:0]   diff_q, diff_d;
  logic                  bout_q, bout_d;
  logic                  invalid_q, invalid_d;
  logic [4*DIGITS-1:0]   a_q, b_q;
  logic                  load;

  logic                  operand_bad;
  logic [3:0]            a_dig, b_dig;
  logic signed [5:0]     t;
  logic                  t_neg;
  logic [3:0]            nib;
  int                    idx;

  // Any nibble above 9 in either latched operand makes the whole operation invalid.
  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) operand_bad = 1'b1;
    end
  end

  always_comb begin
    idx   = int'(cnt_q) * 4;
    a_dig = a_q[idx +: 4];
    b_dig = b_q[idx +: 4];
    t     = $signed({2'b00, a_dig}) - $signed({2'b00, b_dig}) - $signed({5'b0, borrow_q});
    t_neg = t[5];
    nib   = t_neg ? 4'(t + 6'sd10) : t[3:0];
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    invalid_d = invalid_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          diff_d    = '0;
          bout_d    = 1'b0;
          invalid_d = 1'b0;
          cnt_d     = '0;
          borrow_d  = bin;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (operand_bad) begin
          invalid_d = 1'b1;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          diff_d[idx +: 4] = nib;
          borrow_d         = t_neg;
          cnt_d            = cnt_q + CW'(1);
          if (cnt_q == CW'(DIGITS - 1)) begin
            bout_d  = t_neg;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      invalid_q <= invalid_d;
    end
  end

  // NOTE: operand registers are pure data, loaded before any use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign bout    = bout_q;
  assign invalid = invalid_q;

endmodule
